muldiv_unit: RTL and testbench

//  Iterative 32-bit multiply/divide unit for MULT/MULTU/DIV/DIVU; sole producer of HI/LO write data.

---
 rtl/muldiv_unit.sv | 153 +++++++++++++++
 tb/tb_muldiv_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU engine: one shift-add or restoring-subtract step per cycle,
// producing HI/LO write data with a single-cycle write-enable pulse.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             cancel,
  output logic             busy,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             hilo_we
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               rs_neg_q, rs_neg_d;
  logic               rt_zero_q, rt_zero_d;
  logic [WIDTH-1:0]   rs_raw_q, rs_raw_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               we_q, we_d;

  logic               sgn;
  logic [WIDTH-1:0]   rs_abs, rt_abs;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift, div_diff;
  logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;
  logic [WIDTH-1:0]   quot, rem;

  assign sgn    = ~op[0];
  assign rs_abs = (sgn && rs_val[WIDTH-1]) ? -rs_val : rs_val;
  assign rt_abs = (sgn && rt_val[WIDTH-1]) ? -rt_val : rt_val;

  // Multiply: p holds {partial product, remaining multiplier bits}, shifted right each step.
  assign mul_sum  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, (p_q[0] ? m_q : {WIDTH{1'b0}})};
  assign mul_next = {mul_sum, p_q[WIDTH-1:1]};

  // Divide: p holds {remainder, dividend bits shifting out / quotient bits shifting in}.
  assign div_shift = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, m_q};
  assign div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};

  assign prod_fix = neg_q ? -p_q : p_q;
  assign quot     = neg_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
  assign rem      = rs_neg_q ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rs_neg_d  = rs_neg_q;
    rt_zero_d = rt_zero_q;
    rs_raw_d  = rs_raw_q;
    m_d       = m_q;
    p_d       = p_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    we_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && !cancel) begin
          is_div_d  = op[1];
          neg_d     = sgn & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
          rs_neg_d  = sgn & rs_val[WIDTH-1];
          rt_zero_d = (rt_val == '0);
          rs_raw_d  = rs_val;
          m_d       = op[1] ? rt_abs : rs_abs;
          p_d       = {{WIDTH{1'b0}}, (op[1] ? rs_abs : rt_abs)};
          count_d   = '0;
          state_d   = StCalc;
        end
      end
      StCalc: begin
        p_d     = is_div_q ? div_next : mul_next;
        count_d = count_q + 1'b1;
        if (count_q == CW'(WIDTH - 1)) state_d = StFix;
      end
      StFix: begin
        if (!is_div_q) begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else if (rt_zero_q) begin
          hi_d = rs_raw_q;
          lo_d = {WIDTH{1'b1}};
        end else begin
          hi_d = rem;
          lo_d = quot;
        end
        we_d    = 1'b1;
        state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Flush wins over everything, including a pending FIX write.
    if (cancel) begin
      state_d = StIdle;
      we_d    = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      count_q   <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rs_neg_q  <= 1'b0;
      rt_zero_q <= 1'b0;
      rs_raw_q  <= '0;
      m_q       <= '0;
      p_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      we_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rs_neg_q  <= rs_neg_d;
      rt_zero_q <= rt_zero_d;
      rs_raw_q  <= rs_raw_d;
      m_q       <= m_d;
      p_q       <= p_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      we_q      <= we_d;
    end
  end

  assign busy    = (state_q != StIdle);
  assign hi_out  = hi_q;
  assign lo_out  = lo_q;
  assign hilo_we = we_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: arithmetic reference model with latency countdown, per-cycle compare,
// and directed vectors with hand-computed results.
module tb_muldiv_unit;

  localparam int W = 32;

  logic          clk, rst, start, cancel;
  logic [1:0]    op;
  logic [W-1:0]  rs_val, rt_val;
  logic          busy, hilo_we;
  logic [W-1:0]  hi_out, lo_out;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .rs_val  (rs_val),
    .rt_val  (rt_val),
    .cancel  (cancel),
    .busy    (busy),
    .hi_out  (hi_out),
    .lo_out  (lo_out),
    .hilo_we (hilo_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference result straight from the arithmetic definitions.
  function automatic logic [63:0] expected(input logic [1:0] o, input logic [31:0] a,
                                           input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'b00: begin q = sa * sb; u = q; end
      2'b01: u = {32'b0, a} * {32'b0, b};
      2'b10: begin
        if (b == 0) u = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          u = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 0) u = {a, 32'hFFFF_FFFF};
        else u = {a % b, a / b};
      end
    endcase
    return u;
  endfunction

  // Latency model: accepted op keeps busy for W+2 cycles, result shows in the last one.
  int          left;
  logic        m_we;
  logic [31:0] m_hi, m_lo;
  logic [63:0] pend;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      left <= 0;
      m_we <= 1'b0;
      m_hi <= '0;
      m_lo <= '0;
    end else begin
      m_we <= 1'b0;
      if (cancel) left <= 0;
      else if (left == 0) begin
        if (start) begin
          left <= W + 2;
          pend <= expected(op, rs_val, rt_val);
        end
      end else begin
        left <= left - 1;
        if (left == 2) begin
          m_we <= 1'b1;
          m_hi <= pend[63:32];
          m_lo <= pend[31:0];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("busy", {63'b0, busy}, {63'b0, (left != 0)});
      chk("hilo_we", {63'b0, hilo_we}, {63'b0, m_we});
      chk("hi_lo", {hi_out, lo_out}, {m_hi, m_lo});
    end
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #2 start = 1'b1; op = o; rs_val = a; rt_val = b;
    @(posedge clk);
    #2 start = 1'b0;
  endtask

  // Runs one op to completion; optionally pokes a second start mid-flight.
  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] lit, input bit inject);
    int busy_cnt, we_cnt;
    logic [63:0] got;
    busy_cnt = 0;
    we_cnt   = 0;
    got      = '0;
    chk({name, "_model"}, expected(o, a, b), lit);
    issue(o, a, b);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (inject && i == 5) begin
        start = 1'b1; op = 2'b01; rs_val = 32'd2; rt_val = 32'd2;
      end
      if (inject && i == 6) start = 1'b0;
      if (!busy) break;
      busy_cnt++;
      if (hilo_we) begin
        we_cnt++;
        got = {hi_out, lo_out};
      end
    end
    chk({name, "_busy_cycles"}, 64'(busy_cnt), 64'd34);
    chk({name, "_we_pulses"}, 64'(we_cnt), 64'd1);
    chk({name, "_result"}, got, lit);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cancel = 1'b0; op = 2'b00; rs_val = '0; rt_val = '0;
    #1;
    chk("reset_outputs", {29'b0, busy, hilo_we, 1'b0, hi_out}, 64'd0);
    chk("reset_lo", {32'b0, lo_out}, 64'd0);
    #11 rst = 1'b0;

    run_op("mult_neg3x5", 2'b00, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0);
    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0);
    run_op("mult_neg2xneg3", 2'b00, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 64'h0000_0000_0000_0006, 1'b0);
    run_op("divu_100_7", 2'b11, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 1'b0);
    run_op("div_neg7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
    run_op("div_7_neg2", 2'b10, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 1'b0);
    run_op("div_by_zero", 2'b10, 32'h0000_1234, 32'd0, 64'h0000_1234_FFFF_FFFF, 1'b0);
    run_op("divu_by_zero", 2'b11, 32'h8000_0001, 32'd0, 64'h8000_0001_FFFF_FFFF, 1'b0);
    run_op("div_min_neg1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0);

    // Cancel mid-CALC: no write, prior result kept.
    issue(2'b00, 32'd6, 32'd7);
    repeat (9) @(posedge clk);
    #2 cancel = 1'b1;
    @(posedge clk);
    #2 cancel = 1'b0;
    @(negedge clk);
    chk("cancel_busy", {63'b0, busy}, 64'd0);
    chk("cancel_kept", {hi_out, lo_out}, 64'h0000_0000_8000_0000);
    run_op("mult_6x7", 2'b00, 32'd6, 32'd7, 64'h0000_0000_0000_002A, 1'b0);

    // Start together with cancel in IDLE is dropped.
    @(posedge clk);
    #2 start = 1'b1; cancel = 1'b1; op = 2'b01; rs_val = 32'd3; rt_val = 32'd3;
    @(posedge clk);
    #2 start = 1'b0; cancel = 1'b0;
    @(negedge clk);
    chk("start_cancel_busy", {63'b0, busy}, 64'd0);

    run_op("divu_9_3_ignore", 2'b11, 32'd9, 32'd3, 64'h0000_0000_0000_0003, 1'b1);

    // Async reset in CALC clears everything without waiting for a clock.
    issue(2'b11, 32'd50, 32'd5);
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_busy_we", {62'b0, busy, hilo_we}, 64'd0);
    chk("rst_hi_lo", {hi_out, lo_out}, 64'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    run_op("after_rst", 2'b11, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
